// File: rtl/oddr_pair_feeder.sv
// -----------------------------------------------------------------------------
// oddr_pair_feeder
// Serializer that feeds a Gowin ODDR/ODDRC primitive. Parallel words arrive on
// a valid/ready handshake. Each word is presented two bits per clk on d0/d1,
// LSB first: pair k puts bit 2k on d0 and bit 2k+1 on d1. Traffic is held off
// for WARMUP cycles after reset so that the ODDR output has settled. A
// one-entry pending buffer lets consecutive words stream with no gap cycle.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   in_data   word to serialize (WIDTH bits, sent LSB first)
//   in_valid  in_data is valid
//   in_ready  a word can be accepted this cycle (combinational)
//   d0        to ODDR D0: even bit of the current pair (registered)
//   d1        to ODDR D1: odd bit of the current pair (registered)
//   active    d0/d1 carry word data this cycle (registered)
//   warm      warm-up window complete (registered)
// -----------------------------------------------------------------------------
module oddr_pair_feeder #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned WARMUP     = 4,
   parameter logic        IDLE_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             d0,
   output logic             d1,
   output logic             active,
   output logic             warm
);

   localparam int unsigned PW  = $clog2(WIDTH / 2) + 1;
   // A zero-bit counter is not legal, so WARMUP=0 still gets one bit.
   localparam int unsigned WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

   localparam logic [PW-1:0]  PAIRS_INIT = PW'(WIDTH / 2 - 1);
   localparam logic [PW-1:0]  PAIRS_ONE  = PW'(1'b1);
   localparam logic [PW-1:0]  PAIRS_ZERO = {PW{1'b0}};
   localparam logic [WCW-1:0] WCNT_ONE   = WCW'(1'b1);
   // The edge that sees this count is the one that completes warm-up, so
   // warm rises after exactly WARMUP post-reset edges (or the first, if 0).
   localparam logic [WCW-1:0] WARM_LAST  = (WARMUP > 0) ? WCW'(WARMUP - 1) : {WCW{1'b0}};

   typedef enum logic [1:0] {
      ST_WARM  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t           r_state,      w_state;
   logic [WCW-1:0]   r_warm_cnt,   w_warm_cnt;
   logic [WIDTH-1:0] r_shreg,      w_shreg;
   logic [PW-1:0]    r_pairs,      w_pairs;
   logic             r_pend_valid, w_pend_valid;
   logic [WIDTH-1:0] r_pend_data,  w_pend_data;
   logic             r_d0,         w_d0;
   logic             r_d1,         w_d1;
   logic             r_active,     w_active;
   logic             r_warm,       w_warm;

   logic             w_ready;
   logic             w_hs;
   logic             w_load_en;
   logic [WIDTH-1:0] w_load_data;

   assign w_ready  = r_warm && !r_pend_valid;
   assign w_hs     = in_valid && w_ready;

   assign in_ready = w_ready;
   assign d0       = r_d0;
   assign d1       = r_d1;
   assign active   = r_active;
   assign warm     = r_warm;

   // Next-state and next-output logic for the warm-up / idle / shift FSM.
   always_comb begin
      w_state      = r_state;
      w_warm_cnt   = r_warm_cnt;
      w_shreg      = r_shreg;
      w_pairs      = r_pairs;
      w_pend_valid = r_pend_valid;
      w_pend_data  = r_pend_data;
      w_d0         = r_d0;
      w_d1         = r_d1;
      w_active     = r_active;
      w_warm       = r_warm;
      w_load_en    = 1'b0;
      w_load_data  = in_data;

      case (r_state)
         ST_WARM: begin
            if (r_warm_cnt >= WARM_LAST) begin
               w_warm  = 1'b1;
               w_state = ST_IDLE;
            end else begin
               w_warm_cnt = r_warm_cnt + WCNT_ONE;
            end
         end
         ST_IDLE: begin
            if (w_hs) begin
               w_load_en   = 1'b1;
               w_load_data = in_data;
            end else begin
               w_state = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (r_pairs != PAIRS_ZERO) begin
               w_d0    = r_shreg[0];
               w_d1    = r_shreg[1];
               w_shreg = r_shreg >> 2'd2;
               w_pairs = r_pairs - PAIRS_ONE;
               if (w_hs) begin
                  w_pend_valid = 1'b1;
                  w_pend_data  = in_data;
               end else begin
                  w_pend_valid = r_pend_valid;
               end
            end else if (r_pend_valid) begin
               // Last pair is on the outputs: chain the buffered word.
               w_load_en    = 1'b1;
               w_load_data  = r_pend_data;
               w_pend_valid = 1'b0;
            end else if (w_hs) begin
               // Buffer empty but a word is offered: bypass the buffer.
               w_load_en   = 1'b1;
               w_load_data = in_data;
            end else begin
               w_d0     = IDLE_LEVEL;
               w_d1     = IDLE_LEVEL;
               w_active = 1'b0;
               w_state  = ST_IDLE;
            end
         end
         default: begin
            w_state = ST_WARM;
         end
      endcase

      // Common word load: first pair goes straight to the outputs.
      if (w_load_en) begin
         w_d0     = w_load_data[0];
         w_d1     = w_load_data[1];
         w_active = 1'b1;
         w_shreg  = w_load_data >> 2'd2;
         w_pairs  = PAIRS_INIT;
         w_state  = ST_SHIFT;
      end else begin
         w_active = w_active;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_WARM;
         r_warm_cnt   <= {WCW{1'b0}};
         r_shreg      <= {WIDTH{1'b0}};
         r_pairs      <= PAIRS_ZERO;
         r_pend_valid <= 1'b0;
         r_pend_data  <= {WIDTH{1'b0}};
         r_d0         <= IDLE_LEVEL;
         r_d1         <= IDLE_LEVEL;
         r_active     <= 1'b0;
         r_warm       <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_warm_cnt   <= w_warm_cnt;
         r_shreg      <= w_shreg;
         r_pairs      <= w_pairs;
         r_pend_valid <= w_pend_valid;
         r_pend_data  <= w_pend_data;
         r_d0         <= w_d0;
         r_d1         <= w_d1;
         r_active     <= w_active;
         r_warm       <= w_warm;
      end
   end

endmodule
